// File: rtl/elevator_pkg.sv
// Shared constants for the elevator call scheduler: floor range, FSM encodings
// and the default door dwell.
package elevator_pkg;

   localparam int NUM_FLOORS = 4;
   localparam int FLOOR_MIN  = 1;
   localparam int FLOOR_MAX  = 4;

   localparam logic [31:0] DWELL_COUNT_DEFAULT = 32'd5000000;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SERVE = 2'd1;
   localparam logic [1:0] ST_DOOR  = 2'd2;

   // One-hot lamp bit for a floor number; out-of-range floors map to no bit.
   function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [3:0] f);
      logic [NUM_FLOORS-1:0] m;
      m = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (f == 4'(i + 1)) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/call_input_sync.sv
// Per-button 2-flop synchronizer plus a history flop; emits a one-cycle press
// pulse on each synchronized rising edge, so a held button yields one event.
module call_input_sync
   import elevator_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_FLOORS-1:0] btn_raw,
   output logic [NUM_FLOORS-1:0] press
);

   logic [NUM_FLOORS-1:0] s1, s2, s3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= btn_raw;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign press = s2 & ~s3;

endmodule

// File: rtl/elevator_call_scheduler.sv
// Latches floor calls, picks the next target with a sweep (elevator) policy
// and runs the door dwell. state_dbg exposes the FSM state.
module elevator_call_scheduler
   import elevator_pkg::*;
#(
   parameter logic [31:0] DWELL_COUNT = DWELL_COUNT_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] call_btn,
   input  logic [3:0] current_floor,
   input  logic       car_idle,
   output logic [3:0] requested_floor,
   output logic [3:0] call_lamp,
   output logic       door_open,
   output logic       dir_up,
   output logic [1:0] state_dbg
);

   logic [1:0]  state;
   logic [31:0] dwell_cnt;
   logic [3:0]  press_evt;

   call_input_sync u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (call_btn),
      .press   (press_evt)
   );

   logic       here_hit, have_up, have_dn, sel_valid, sel_flip;
   logic [3:0] up_tgt, dn_tgt, sel_tgt;

   // Target selection: stop here, else nearest ahead, else nearest behind (reverse).
   always_comb begin
      here_hit = car_idle && (|(call_lamp & floor_mask(current_floor)));
      have_up  = 1'b0;
      have_dn  = 1'b0;
      up_tgt   = 4'd1;
      dn_tgt   = 4'd1;
      for (int f = FLOOR_MAX; f >= FLOOR_MIN; f--) begin
         if (call_lamp[2'(f - 1)] && (4'(f) > current_floor)) begin
            have_up = 1'b1;
            up_tgt  = 4'(f);
         end
      end
      for (int f = FLOOR_MIN; f <= FLOOR_MAX; f++) begin
         if (call_lamp[2'(f - 1)] && (4'(f) < current_floor)) begin
            have_dn = 1'b1;
            dn_tgt  = 4'(f);
         end
      end
      sel_valid = 1'b1;
      sel_flip  = 1'b0;
      sel_tgt   = requested_floor;
      if (here_hit) begin
         sel_tgt = current_floor;
      end else if (dir_up ? have_up : have_dn) begin
         sel_tgt = dir_up ? up_tgt : dn_tgt;
      end else if (dir_up ? have_dn : have_up) begin
         sel_tgt  = dir_up ? dn_tgt : up_tgt;
         sel_flip = 1'b1;
      end else begin
         sel_valid = 1'b0;
      end
   end

   logic       arrive, enter_door, door_press;
   logic [3:0] lamp_set, lamp_clr, lamp_next;

   // The door floor's lamp is never relit while the door is open; a clear beats a set.
   always_comb begin
      arrive     = car_idle && (current_floor == requested_floor)
                   && (|(call_lamp & floor_mask(requested_floor)));
      enter_door = ((state == ST_IDLE) && (call_lamp != 4'd0) && here_hit)
                   || ((state == ST_SERVE) && arrive);
      door_press = (state == ST_DOOR) && (|(press_evt & floor_mask(requested_floor)));
      lamp_set   = press_evt & ~((state == ST_DOOR) ? floor_mask(requested_floor) : 4'd0);
      lamp_clr   = enter_door ? floor_mask(current_floor) : 4'd0;
      lamp_next  = (call_lamp | lamp_set) & ~lamp_clr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         requested_floor <= 4'd1;
         call_lamp       <= 4'd0;
         door_open       <= 1'b0;
         dir_up          <= 1'b1;
         dwell_cnt       <= 32'd0;
      end else begin
         call_lamp <= lamp_next;
         case (state)
            ST_IDLE: begin
               if (enter_door) begin
                  state           <= ST_DOOR;
                  requested_floor <= current_floor;
                  door_open       <= 1'b1;
                  dwell_cnt       <= 32'd0;
               end else if (call_lamp != 4'd0) begin
                  state <= ST_SERVE;
                  if (sel_valid) begin
                     requested_floor <= sel_tgt;
                     if (sel_flip) dir_up <= ~dir_up;
                  end
               end
            end
            ST_SERVE: begin
               if (enter_door) begin
                  state     <= ST_DOOR;
                  door_open <= 1'b1;
                  dwell_cnt <= 32'd0;
               end else if (call_lamp == 4'd0) begin
                  state <= ST_IDLE;
               end else if (sel_valid) begin
                  requested_floor <= sel_tgt;
                  if (sel_flip) dir_up <= ~dir_up;
               end
            end
            ST_DOOR: begin
               if (door_press) begin
                  dwell_cnt <= 32'd0;
               end else if (dwell_cnt == DWELL_COUNT - 32'd1) begin
                  door_open <= 1'b0;
                  state     <= (lamp_next != 4'd0) ? ST_SERVE : ST_IDLE;
               end else begin
                  dwell_cnt <= dwell_cnt + 32'd1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               door_open <= 1'b0;
            end
         endcase
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Scenario bench for elevator_call_scheduler with DWELL_COUNT=8; expected
// values are queued when stimulus is driven and popped when outputs are sampled.
module tb_elevator_call_scheduler;
   import elevator_pkg::*;

   localparam int W = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] call_btn = 4'd0;
   logic [3:0] current_floor = 4'd1;
   logic       car_idle = 1'b0;
   logic [3:0] requested_floor, call_lamp;
   logic       door_open, dir_up;
   logic [1:0] state_dbg;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_v;
   logic [W-1:0] obs_v;
   int n_checks = 0;
   int n_fail = 0;

   int   press_cnt[4];
   logic count_en = 1'b0;

   // clock / reset block
   always #5 clk = ~clk;

   elevator_call_scheduler #(.DWELL_COUNT(32'd8)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .call_btn        (call_btn),
      .current_floor   (current_floor),
      .car_idle        (car_idle),
      .requested_floor (requested_floor),
      .call_lamp       (call_lamp),
      .door_open       (door_open),
      .dir_up          (dir_up),
      .state_dbg       (state_dbg)
   );

   always @(negedge clk) begin
      if (count_en) begin
         for (int i = 0; i < 4; i++) begin
            if (dut.press_evt[i]) press_cnt[i] = press_cnt[i] + 1;
         end
      end
   end

   function automatic logic [W-1:0] pack(input logic [1:0] st, input logic d, input logic o,
                                         input logic [3:0] l, input logic [3:0] r);
      return {4'h0, st, d, o, l, r};
   endfunction

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      call_btn = 4'd0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic pulse_btn(input logic [3:0] m);
      call_btn = m;
      tick();
      call_btn = 4'd0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      exp_q.push_back(pack(ST_IDLE, 1'b1, 1'b0, 4'd0, 4'd1));
      tick();
      tick();
      obs_v = pack(state_dbg, dir_up, door_open, call_lamp, requested_floor);
      exp_v = exp_q.pop_front(); n_checks++;
      if (obs_v !== exp_v) begin n_fail++; $display("FAIL reset_values: got %h want %h", obs_v, exp_v); end
      rst_n = 1'b1;
   endtask

   task automatic test_lamp_latency();
      do_reset();
      current_floor = 4'd1; car_idle = 1'b1;
      exp_q.push_back(pack(ST_IDLE, 1'b1, 1'b0, 4'b0000, 4'd1));
      exp_q.push_back(pack(ST_IDLE, 1'b1, 1'b0, 4'b0100, 4'd1));
      exp_q.push_back(pack(ST_SERVE, 1'b1, 1'b0, 4'b0100, 4'd3));
      pulse_btn(4'b0100);
      for (int k = 0; k < 3; k++) begin
         tick();
         obs_v = pack(state_dbg, dir_up, door_open, call_lamp, requested_floor);
         exp_v = exp_q.pop_front(); n_checks++;
         if (obs_v !== exp_v) begin n_fail++; $display("FAIL lamp_latency_%0d: got %h want %h", k, obs_v, exp_v); end
      end
   endtask

   task automatic test_retarget_and_dwell();
      int cnt;
      do_reset();
      current_floor = 4'd1; car_idle = 1'b1;
      pulse_btn(4'b1000);
      tick(); tick(); tick();
      exp_q.push_back(pack(ST_SERVE, 1'b1, 1'b0, 4'b1000, 4'd4));
      obs_v = pack(state_dbg, dir_up, door_open, call_lamp, requested_floor);
      exp_v = exp_q.pop_front(); n_checks++;
      if (obs_v !== exp_v) begin n_fail++; $display("FAIL head_to_4: got %h want %h", obs_v, exp_v); end
      current_floor = 4'd2; car_idle = 1'b0;
      exp_q.push_back(pack(ST_SERVE, 1'b1, 1'b0, 4'b1100, 4'd4));
      exp_q.push_back(pack(ST_SERVE, 1'b1, 1'b0, 4'b1100, 4'd3));
      pulse_btn(4'b0100);
      tick();
      for (int k = 0; k < 2; k++) begin
         tick();
         obs_v = pack(state_dbg, dir_up, door_open, call_lamp, requested_floor);
         exp_v = exp_q.pop_front(); n_checks++;
         if (obs_v !== exp_v) begin n_fail++; $display("FAIL retarget_%0d: got %h want %h", k, obs_v, exp_v); end
      end
      current_floor = 4'd3; car_idle = 1'b1;
      exp_q.push_back(pack(ST_DOOR, 1'b1, 1'b1, 4'b1000, 4'd3));
      tick();
      obs_v = pack(state_dbg, dir_up, door_open, call_lamp, requested_floor);
      exp_v = exp_q.pop_front(); n_checks++;
      if (obs_v !== exp_v) begin n_fail++; $display("FAIL door_entry: got %h want %h", obs_v, exp_v); end
      exp_q.push_back(W'(8));
      cnt = 0;
      while (door_open === 1'b1 && cnt < 40) begin cnt++; tick(); end
      exp_v = exp_q.pop_front(); n_checks++;
      if (cnt !== int'(exp_v)) begin n_fail++; $display("FAIL dwell_len: got %0d want %0d", cnt, exp_v); end
      exp_q.push_back(pack(ST_SERVE, 1'b1, 1'b0, 4'b1000, 4'd3));
      exp_q.push_back(pack(ST_SERVE, 1'b1, 1'b0, 4'b1000, 4'd4));
      for (int k = 0; k < 2; k++) begin
         obs_v = pack(state_dbg, dir_up, door_open, call_lamp, requested_floor);
         exp_v = exp_q.pop_front(); n_checks++;
         if (obs_v !== exp_v) begin n_fail++; $display("FAIL after_door_%0d: got %h want %h", k, obs_v, exp_v); end
         tick();
      end
   endtask

   task automatic test_reverse();
      do_reset();
      current_floor = 4'd3; car_idle = 1'b0;
      exp_q.push_back(pack(ST_IDLE, 1'b1, 1'b0, 4'b0011, 4'd1));
      exp_q.push_back(pack(ST_SERVE, 1'b0, 1'b0, 4'b0011, 4'd2));
      pulse_btn(4'b0011);
      tick();
      for (int k = 0; k < 2; k++) begin
         tick();
         obs_v = pack(state_dbg, dir_up, door_open, call_lamp, requested_floor);
         exp_v = exp_q.pop_front(); n_checks++;
         if (obs_v !== exp_v) begin n_fail++; $display("FAIL reverse_%0d: got %h want %h", k, obs_v, exp_v); end
      end
   endtask

   task automatic test_door_repress();
      int   cnt;
      int   guard;
      logic saw_lamp;
      do_reset();
      current_floor = 4'd2; car_idle = 1'b1;
      pulse_btn(4'b0010);
      tick(); tick(); tick();
      exp_q.push_back(pack(ST_DOOR, 1'b1, 1'b1, 4'b0000, 4'd2));
      obs_v = pack(state_dbg, dir_up, door_open, call_lamp, requested_floor);
      exp_v = exp_q.pop_front(); n_checks++;
      if (obs_v !== exp_v) begin n_fail++; $display("FAIL direct_door: got %h want %h", obs_v, exp_v); end
      cnt = 1; saw_lamp = 1'b0; guard = 0;
      repeat (2) begin tick(); if (door_open) cnt++; end
      call_btn = 4'b0010;
      tick(); if (door_open) cnt++;
      call_btn = 4'b0000;
      while (door_open === 1'b1 && guard < 60) begin
         tick(); guard++;
         if (door_open) cnt++;
         if (call_lamp != 4'd0) saw_lamp = 1'b1;
      end
      exp_q.push_back(W'(13));
      exp_v = exp_q.pop_front(); n_checks++;
      if (cnt !== int'(exp_v)) begin n_fail++; $display("FAIL repress_dwell: got %0d want %0d", cnt, exp_v); end
      exp_q.push_back(W'(0));
      exp_v = exp_q.pop_front(); n_checks++;
      if (saw_lamp !== exp_v[0]) begin n_fail++; $display("FAIL repress_lamp: got %b want %b", saw_lamp, exp_v[0]); end
      exp_q.push_back(pack(ST_IDLE, 1'b1, 1'b0, 4'b0000, 4'd2));
      obs_v = pack(state_dbg, dir_up, door_open, call_lamp, requested_floor);
      exp_v = exp_q.pop_front(); n_checks++;
      if (obs_v !== exp_v) begin n_fail++; $display("FAIL repress_exit: got %h want %h", obs_v, exp_v); end
   endtask

   task automatic test_hold_and_async_reset();
      do_reset();
      current_floor = 4'd1; car_idle = 1'b0;
      for (int i = 0; i < 4; i++) press_cnt[i] = 0;
      count_en = 1'b1;
      call_btn = 4'b1111;
      repeat (100) tick();
      count_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(W'(1));
         exp_v = exp_q.pop_front(); n_checks++;
         if (press_cnt[i] !== int'(exp_v)) begin n_fail++; $display("FAIL hold_events_f%0d: got %0d want %0d", i + 1, press_cnt[i], exp_v); end
      end
      exp_q.push_back(pack(ST_SERVE, 1'b1, 1'b0, 4'b1111, 4'd2));
      obs_v = pack(state_dbg, dir_up, door_open, call_lamp, requested_floor);
      exp_v = exp_q.pop_front(); n_checks++;
      if (obs_v !== exp_v) begin n_fail++; $display("FAIL hold_serve: got %h want %h", obs_v, exp_v); end
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.push_back(pack(ST_IDLE, 1'b1, 1'b0, 4'b0000, 4'd1));
      obs_v = pack(state_dbg, dir_up, door_open, call_lamp, requested_floor);
      exp_v = exp_q.pop_front(); n_checks++;
      if (obs_v !== exp_v) begin n_fail++; $display("FAIL async_reset: got %h want %h", obs_v, exp_v); end
      tick(); tick();
      for (int i = 0; i < 4; i++) press_cnt[i] = 0;
      count_en = 1'b1;
      rst_n = 1'b1;
      repeat (10) tick();
      count_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(W'(1));
         exp_v = exp_q.pop_front(); n_checks++;
         if (press_cnt[i] !== int'(exp_v)) begin n_fail++; $display("FAIL held_thru_reset_f%0d: got %0d want %0d", i + 1, press_cnt[i], exp_v); end
      end
      call_btn = 4'd0;
   endtask

   task automatic test_bad_floor();
      logic saw_door;
      logic bad_req;
      do_reset();
      current_floor = 4'd0; car_idle = 1'b1;
      pulse_btn(4'b0001);
      tick(); tick();
      saw_door = 1'b0; bad_req = 1'b0;
      repeat (20) begin
         tick();
         if (door_open) saw_door = 1'b1;
         if (requested_floor < 4'd1 || requested_floor > 4'd4) bad_req = 1'b1;
      end
      exp_q.push_back(W'(0));
      exp_v = exp_q.pop_front(); n_checks++;
      if (saw_door !== exp_v[0]) begin n_fail++; $display("FAIL bad_floor_door: got %b want %b", saw_door, exp_v[0]); end
      exp_q.push_back(W'(0));
      exp_v = exp_q.pop_front(); n_checks++;
      if (bad_req !== exp_v[0]) begin n_fail++; $display("FAIL bad_floor_range: got %b want %b", bad_req, exp_v[0]); end
      exp_q.push_back(pack(ST_SERVE, 1'b1, 1'b0, 4'b0001, 4'd1));
      obs_v = pack(state_dbg, dir_up, door_open, call_lamp, requested_floor);
      exp_v = exp_q.pop_front(); n_checks++;
      if (obs_v !== exp_v) begin n_fail++; $display("FAIL bad_floor_state: got %h want %h", obs_v, exp_v); end
   endtask

   initial begin
      test_reset();
      test_lamp_latency();
      test_retarget_and_dwell();
      test_reverse();
      test_door_repress();
      test_hold_and_async_reset();
      test_bad_floor();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/elevator_call_scheduler.md
ELEVATOR_CALL_SCHEDULER -- requirements
Module: elevator_call_scheduler

Interface
REQ-001 Parameter DWELL_COUNT, default 32'd5000000, door-open dwell in clk cycles (bench uses 8).
REQ-002 Port clk  input  1  single system clock; all state on its rising edge.
REQ-003 Port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port call_btn  input  4  raw, asynchronous call buttons; bit i = floor i+1.
REQ-005 Port current_floor  input  4  car position from the elevator controller, valid range 1..4.
REQ-006 Port car_idle  input  1  high when the elevator controller is stopped (its idle display).
REQ-007 Port requested_floor  output  4  registered target floor driven to the elevator controller, range 1..4.
REQ-008 Port call_lamp  output  4  registered pending-call mask; bit i lit while floor i+1 is unserved.
REQ-009 Port door_open  output  1  registered; high during door dwell.
REQ-010 Port dir_up  output  1  registered sweep direction; 1 = up, 0 = down.

Function
REQ-011 Each call_btn bit SHALL pass a 2-flop synchronizer plus a third flop; a press event is s2 & ~s3, and holding a button SHALL produce exactly one event.
REQ-012 A press event SHALL set its call_lamp bit; a raw rise meeting setup before edge N SHALL make the lamp visible after edge N+2.
REQ-013 The FSM SHALL have three states: IDLE, SERVE and DOOR; undefined encodings SHALL go to IDLE.
REQ-014 Target selection, in priority order: (a) the current floor, if its bit is pending and car_idle=1; (b) in the dir_up direction, the nearest pending floor strictly beyond current_floor; (c) otherwise, the nearest pending floor in the opposite direction, with dir_up toggled on the same edge.
REQ-015 IDLE: if call_lamp is nonzero, then on the next edge enter SERVE and load requested_floor with the selected target; a pending current floor with car_idle=1 SHALL enter DOOR directly.
REQ-016 SERVE: requested_floor SHALL be re-evaluated each cycle, so a new closer call in the sweep direction retargets one cycle after its lamp sets.
REQ-017 SERVE -> DOOR when car_idle=1, current_floor==requested_floor, and that floor is pending; on that edge the bit clears, the dwell counter zeroes, and door_open rises.
REQ-018 DOOR: requested_floor SHALL hold current_floor; when the counter reaches DWELL_COUNT-1, exit to SERVE if any lamp is lit, else IDLE; door_open falls on the exit edge.
REQ-019 A press for the door floor during DOOR SHALL restart the counter and SHALL NOT light its lamp; presses for other floors latch normally.
REQ-020 A same-cycle press and clear on one floor: the clear wins; on different floors, both take effect.
REQ-021 current_floor outside 1..4 SHALL match no floor and SHALL never be selected; requested_floor SHALL never leave 1..4.
REQ-022 With no pending calls, requested_floor SHALL keep its last value.

Reset
REQ-023 While rst_n=0 (asynchronous): state=IDLE, requested_floor=1, call_lamp=0, door_open=0, dir_up=1, dwell counter=0, and all synchronizer flops=0.
REQ-024 Reset asserted mid-operation (any state) SHALL discard all pending calls; a button held through reset release SHALL register one event.

Structure
REQ-025 The shared package elevator_pkg SHALL hold NUM_FLOORS=4, floor limits 1/4, the FSM state encodings and the DWELL_COUNT default.
REQ-026 There SHALL be one sub-module, call_input_sync: the per-bit 3-flop synchronizer and rise detector, 4 bits wide.
REQ-027 The target-selection logic SHALL be purely combinational from call_lamp, current_floor and dir_up; all outputs are registered.

Verification
REQ-028 Reset, then pulse call_btn[2] with current_floor=1 and car_idle=1 -> lamp 4'b0100 after 3 edges, then requested_floor=3, state SERVE, and dir_up=1.
REQ-029 At current_floor=1 heading to 4, press floor 3 while current_floor=2 -> requested_floor changes to 3; on arrival at 3, door_open is high for 8 cycles, then requested_floor=4.
REQ-030 At current_floor=3 with dir_up=1, calls for floors 1 and 2 only -> dir_up=0 and requested_floor=2 on the same edge.
REQ-031 During DOOR at floor 2 (DWELL_COUNT=8), re-press floor 2 at count 5 -> the lamp stays 0 and door_open lasts 5+8 cycles in total.
REQ-032 Hold call_btn=4'b1111 for 100 cycles -> exactly one event per floor; assert rst_n=0 in SERVE -> all outputs at reset values immediately, without a clock.
REQ-033 Drive current_floor=0 with car_idle=1 and floor 1 pending -> no DOOR entry, and requested_floor stays within 1..4.
